bpm_packet_collector: RTL

Consumes the merged 112-bit BPM readback stream produced by the two-link BPM FIFO/arbiter, validates each word, and sorts X/Y/Sum into a per-BPM readout RAM for one fast-acquisition (FA) cycle. An FA sync pulse opens a collection window. The window closes when every expected BPM has reported or a timeout expires. Closing the window latches a seen-bitmap and pulses `cycle_done` for the downstream orbit-feedback computation.

---
 rtl/bpm_packet_collector.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/bpm_packet_collector.sv
// bpm_packet_collector
//   Collects one fast-acquisition cycle of merged BPM readback words. Each word
//   is validated and sorted into a per-BPM readout RAM. The collection window
//   opens on FA_SYNC. It closes when all NBPM BPMs have reported or when
//   TIMEOUT cycles have elapsed. On close, the seen-bitmap and the unique
//   count are latched and cycle_done pulses for one cycle.
//
//   Optional feature macro: BPM_SUM_CHECK_EN (low-signal Sum rejection).
//
// Ports
//   ACLK, ARESET        clock, async active-high reset
//   FA_SYNC             one-cycle pulse that starts a new cycle
//   S00_AXIS_*          112-bit input stream {hdr, idx, X, Y, Sum}; TREADY is state-only
//   rd_addr / rd_data   readout RAM port, 1-cycle latency, returns {X,Y,Sum}
//   cycle_done          one-cycle pulse at window close
//   timed_out           last window closed without full coverage (latched)
//   seen, good_count    bitmap / unique count of the last window (latched)
//   *_count             16-bit saturating error counters
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for FA_SYNC; accepted words are strays
// S_CLEAR   | one cycle: zero working bitmap, unique counter, timer
// S_COLLECT | window open; classify and store words
// S_DONE    | one cycle: pulse cycle_done, latch seen/good_count
module bpm_packet_collector #(
    parameter int          NBPM    = 32,
    parameter int          TIMEOUT = 5000,
    parameter logic [7:0]  HDR     = 8'hA5,
    parameter logic [31:0] SUM_MIN = 32'd1000,
    parameter int          AW      = (NBPM > 1) ? $clog2(NBPM) : 1
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            FA_SYNC,
    input  logic            S00_AXIS_TVALID,
    input  logic [111:0]    S00_AXIS_TDATA,
    output logic            S00_AXIS_TREADY,
    input  logic [AW-1:0]   rd_addr,
    output logic [95:0]     rd_data,
    output logic            cycle_done,
    output logic            timed_out,
    output logic [NBPM-1:0] seen,
    output logic [8:0]      good_count,
    output logic [15:0]     bad_hdr_count,
    output logic [15:0]     dup_count,
    output logic [15:0]     stray_count,
    output logic [15:0]     low_sum_count
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COLLECT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [NBPM-1:0]   bitmap_q, bitmap_d;
    logic [8:0]        uniq_q, uniq_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              restart_q, restart_d;
    logic              timed_out_q, timed_out_d;
    logic [NBPM-1:0]   seen_q, seen_d;
    logic [8:0]        good_q, good_d;
    logic [15:0]       bad_q, bad_d, dup_q, dup_d, stray_q, stray_d;
    logic              bad_inc, dup_inc, stray_inc, wr_en;
    logic [95:0]       mem_q [NBPM];
    logic [95:0]       rd_data_q;

    logic [7:0]        hdr;
    logic [7:0]        idx;
    logic [AW-1:0]     idx_a;
    logic [95:0]       payload;
    logic              accept, idx_ok, rd_ok;

    assign hdr     = S00_AXIS_TDATA[111:104];
    assign idx     = S00_AXIS_TDATA[103:96];
    assign payload = S00_AXIS_TDATA[95:0];
    assign idx_a   = idx[AW-1:0];
    assign idx_ok  = (32'(idx) < NBPM);
    assign rd_ok   = (32'(rd_addr) < NBPM);

    assign S00_AXIS_TREADY = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign accept          = S00_AXIS_TVALID && S00_AXIS_TREADY;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

`ifdef BPM_SUM_CHECK_EN
    logic        low_inc;
    logic [15:0] low_q, low_d;
    logic        sum_low;
    assign sum_low = (S00_AXIS_TDATA[31:0] < SUM_MIN);
`endif

    always_comb begin
        state_d     = state_q;
        bitmap_d    = bitmap_q;
        uniq_d      = uniq_q;
        timer_d     = timer_q;
        restart_d   = restart_q;
        timed_out_d = timed_out_q;
        seen_d      = seen_q;
        good_d      = good_q;
        bad_inc     = 1'b0;
        dup_inc     = 1'b0;
        stray_inc   = 1'b0;
        wr_en       = 1'b0;
`ifdef BPM_SUM_CHECK_EN
        low_inc     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                stray_inc = accept;
                if (FA_SYNC) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                bitmap_d = '0;
                uniq_d   = '0;
                timer_d  = '0;
                state_d  = S_COLLECT;
            end
            S_COLLECT: begin
                timer_d = timer_q + 1'b1;
                if (accept) begin
                    if ((hdr != HDR) || !idx_ok) begin
                        bad_inc = 1'b1;
                    end else if (bitmap_q[idx_a]) begin
                        dup_inc = 1'b1;
`ifdef BPM_SUM_CHECK_EN
                    end else if (sum_low) begin
                        low_inc = 1'b1;
`endif
                    end else begin
                        wr_en           = 1'b1;
                        bitmap_d[idx_a] = 1'b1;
                        uniq_d          = uniq_q + 9'd1;
                    end
                end
                // Full coverage wins over timeout/sync when both land on the same edge.
                if (uniq_d == 9'(NBPM)) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b0;
                end else if ((timer_q == TW'(TIMEOUT - 1)) || FA_SYNC) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b1;
                end
                if (FA_SYNC) restart_d = 1'b1;
            end
            S_DONE: begin
                seen_d    = bitmap_q;
                good_d    = uniq_q;
                restart_d = 1'b0;
                state_d   = (restart_q || FA_SYNC) ? S_CLEAR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        bad_d   = sat_inc(bad_q, bad_inc);
        dup_d   = sat_inc(dup_q, dup_inc);
        stray_d = sat_inc(stray_q, stray_inc);
`ifdef BPM_SUM_CHECK_EN
        low_d   = sat_inc(low_q, low_inc);
`endif
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            bitmap_q    <= '0;
            uniq_q      <= '0;
            timer_q     <= '0;
            restart_q   <= 1'b0;
            timed_out_q <= 1'b0;
            seen_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            dup_q       <= '0;
            stray_q     <= '0;
        end else begin
            state_q     <= state_d;
            bitmap_q    <= bitmap_d;
            uniq_q      <= uniq_d;
            timer_q     <= timer_d;
            restart_q   <= restart_d;
            timed_out_q <= timed_out_d;
            seen_q      <= seen_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            dup_q       <= dup_d;
            stray_q     <= stray_d;
        end
    end

`ifdef BPM_SUM_CHECK_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) low_q <= '0;
        else        low_q <= low_d;
    end
    assign low_sum_count = low_q;
`else
    localparam logic [31:0] sum_min_unused = SUM_MIN;
    assign low_sum_count = '0;
`endif

    // Readout RAM is not reset; read-before-write gives old data on collision.
    always_ff @(posedge ACLK) begin
        if (wr_en) mem_q[idx_a] <= payload;
        rd_data_q <= rd_ok ? mem_q[rd_addr] : '0;
    end

    assign rd_data       = rd_data_q;
    assign cycle_done    = (state_q == S_DONE);
    assign timed_out     = timed_out_q;
    assign seen          = seen_q;
    assign good_count    = good_q;
    assign bad_hdr_count = bad_q;
    assign dup_count     = dup_q;
    assign stray_count   = stray_q;

endmodule
